frv_mem_arbiter: RTL and testbench



---
 rtl/frv_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_frv_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frv_mem_arbiter.sv
// Two-port (imem/dmem) to single memory bus arbiter with an in-order response routing FIFO.
// Optional macro FRV_MEM_ARB_RR_EN switches IDLE arbitration from fixed dmem priority to round-robin.
`timescale 1ns/1ps
module frv_mem_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            g_clk,
    input  logic            g_resetn,

    input  logic            imem_req,
    input  logic            imem_wen,
    input  logic [3:0]      imem_strb,
    input  logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_wdata,
    output logic            imem_gnt,
    output logic            imem_recv,
    input  logic            imem_ack,
    output logic            imem_error,
    output logic [XLEN-1:0] imem_rdata,

    input  logic            dmem_req,
    input  logic            dmem_wen,
    input  logic [3:0]      dmem_strb,
    input  logic [XLEN-1:0] dmem_addr,
    input  logic [XLEN-1:0] dmem_wdata,
    output logic            dmem_gnt,
    output logic            dmem_recv,
    input  logic            dmem_ack,
    output logic            dmem_error,
    output logic [XLEN-1:0] dmem_rdata,

    output logic            bus_req,
    output logic            bus_wen,
    output logic [3:0]      bus_strb,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_gnt,
    input  logic            bus_recv,
    input  logic            bus_error,
    input  logic [XLEN-1:0] bus_rdata,
    output logic            bus_ack,
    output logic            err_unexpected
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } state_t;

    state_t           state;
    logic [DEPTH-1:0] owner_q;      // 1 = dmem owns the entry
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;

    logic full;
    logic empty;
    logic sel_d;
    logic req_sel;
    logic idle_pick_d;
    logic push;
    logic pop;
    logic head_d;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

`ifdef FRV_MEM_ARB_RR_EN
    logic rr_last_d;

    // The last granted side loses the next contention; only a real push moves the pointer.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn)
            rr_last_d <= 1'b0;
        else if (push)
            rr_last_d <= sel_d;
    end

    assign idle_pick_d = dmem_req & (~imem_req | ~rr_last_d);
`else
    assign idle_pick_d = dmem_req;
`endif

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        sel_d   = 1'b0;
        req_sel = 1'b0;
        case (state)
            HOLD_I: begin
                sel_d   = 1'b0;
                req_sel = imem_req;
            end
            HOLD_D: begin
                sel_d   = 1'b1;
                req_sel = dmem_req;
            end
            default: begin
                sel_d   = idle_pick_d;
                req_sel = imem_req | dmem_req;
            end
        endcase
    end

    // NOTE: reset also masks the request combinationally so nothing is issued while held in reset.
    assign bus_req   = g_resetn & ~full & req_sel;
    assign bus_wen   = bus_req & (sel_d ? dmem_wen : imem_wen);
    assign bus_strb  = bus_req ? (sel_d ? dmem_strb  : imem_strb)  : '0;
    assign bus_addr  = bus_req ? (sel_d ? dmem_addr  : imem_addr)  : '0;
    assign bus_wdata = bus_req ? (sel_d ? dmem_wdata : imem_wdata) : '0;

    assign push     = bus_req & bus_gnt;
    assign imem_gnt = push & ~sel_d;
    assign dmem_gnt = push &  sel_d;

    assign head_d     = owner_q[rd_ptr];
    assign imem_recv  = bus_recv & ~empty & ~head_d;
    assign dmem_recv  = bus_recv & ~empty &  head_d;
    assign imem_error = imem_recv & bus_error;
    assign dmem_error = dmem_recv & bus_error;
    assign imem_rdata = imem_recv ? bus_rdata : '0;
    assign dmem_rdata = dmem_recv ? bus_rdata : '0;

    // With nothing outstanding the beat is acknowledged anyway so the bus never wedges.
    assign bus_ack        = empty ? bus_recv : (head_d ? dmem_ack : imem_ack);
    assign pop            = bus_recv & bus_ack & ~empty;
    assign err_unexpected = g_resetn & bus_recv & empty;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (bus_req && !bus_gnt) state <= sel_d ? HOLD_D : HOLD_I;
                HOLD_I:  if (!imem_req || push)   state <= IDLE;
                HOLD_D:  if (!dmem_req || push)   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the owner storage is only DEPTH bits, so it is reset along with the pointers.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            owner_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                owner_q[wr_ptr] <= sel_d;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// Randomized scoreboard bench for frv_mem_arbiter: a transaction-level model predicts grants and
// routing; a separate monitor pops expected responses whenever a requester completes a beat.
`timescale 1ns/1ps
module tb_frv_mem_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            g_clk = 1'b0;
    logic            g_resetn = 1'b0;
    logic            imem_req, imem_wen, imem_gnt, imem_recv, imem_ack, imem_error;
    logic [3:0]      imem_strb;
    logic [XLEN-1:0] imem_addr, imem_wdata, imem_rdata;
    logic            dmem_req, dmem_wen, dmem_gnt, dmem_recv, dmem_ack, dmem_error;
    logic [3:0]      dmem_strb;
    logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic            bus_req, bus_wen, bus_gnt, bus_recv, bus_error, bus_ack, err_unexpected;
    logic [3:0]      bus_strb;
    logic [XLEN-1:0] bus_addr, bus_wdata, bus_rdata;

    frv_mem_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .imem_req(imem_req), .imem_wen(imem_wen), .imem_strb(imem_strb),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_gnt(imem_gnt),
        .imem_recv(imem_recv), .imem_ack(imem_ack), .imem_error(imem_error),
        .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_recv(dmem_recv), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
        .dmem_rdata(dmem_rdata),
        .bus_req(bus_req), .bus_wen(bus_wen), .bus_strb(bus_strb), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_recv(bus_recv),
        .bus_error(bus_error), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .err_unexpected(err_unexpected)
    );

    always #5 g_clk = ~g_clk;

    typedef struct { logic [31:0] rdata; logic err; } resp_t;
    typedef struct { logic wen; logic [3:0] strb; logic [31:0] addr; logic [31:0] wdata; } reqp_t;

    int checks   = 0;
    int failures = 0;

    // Reference model: outstanding owners in issue order, the held requester, the RR history.
    int    ref_q[$];
    int    lock    = -1;
    int    rr_last = 0;
    resp_t mem_q[$];
    resp_t exp_q0[$];
    resp_t exp_q1[$];
    logic  pend[2];
    reqp_t preq[2];
    resp_t mon_r;

    int req_pct, gnt_pct, recv_pct, ack_pct, drop_pct, unexp_pct;
    int force_gnt = -1;
    bit drove_mem;
    bit use_override = 1'b0;
    logic [31:0] resp_override;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [159:0] all_outputs();
        return {imem_gnt, imem_recv, imem_error, imem_rdata, dmem_gnt, dmem_recv, dmem_error,
                dmem_rdata, bus_req, bus_wen, bus_strb, bus_addr, bus_wdata, bus_ack,
                err_unexpected};
    endfunction

    task automatic set_knobs(input int rq, input int gn, input int rc, input int ak,
                             input int dr, input int un);
        req_pct = rq; gnt_pct = gn; recv_pct = rc; ack_pct = ak; drop_pct = dr; unexp_pct = un;
    endtask

    task automatic drive_zero();
        {imem_req, imem_wen, imem_strb, imem_addr, imem_wdata, imem_ack} = '0;
        {dmem_req, dmem_wen, dmem_strb, dmem_addr, dmem_wdata, dmem_ack} = '0;
        {bus_gnt, bus_recv, bus_error, bus_rdata} = '0;
    endtask

    task automatic drive_inputs();
        drive_zero();
        imem_req = pend[0];
        dmem_req = pend[1];
        if (pend[0]) {imem_wen, imem_strb, imem_addr, imem_wdata} =
            {preq[0].wen, preq[0].strb, preq[0].addr, preq[0].wdata};
        if (pend[1]) {dmem_wen, dmem_strb, dmem_addr, dmem_wdata} =
            {preq[1].wen, preq[1].strb, preq[1].addr, preq[1].wdata};
        bus_gnt  = (force_gnt >= 0) ? (force_gnt == 1) : ($urandom_range(99) < gnt_pct);
        imem_ack = $urandom_range(99) < ack_pct;
        dmem_ack = $urandom_range(99) < ack_pct;
        drove_mem = 1'b0;
        if (mem_q.size() > 0) begin
            if ($urandom_range(99) < recv_pct) begin
                bus_recv  = 1'b1;
                bus_rdata = mem_q[0].rdata;
                bus_error = mem_q[0].err;
                drove_mem = 1'b1;
            end
        end else if ($urandom_range(99) < unexp_pct) begin
            bus_recv  = 1'b1;
            bus_rdata = $urandom;
        end
    endtask

    // Predicts this cycle's combinational outputs from the transaction-level state, then advances it.
    task automatic check_update();
        bit full = (ref_q.size() == DEPTH);
        bit ereq = 1'b0;
        int win  = 0;
        int h    = (ref_q.size() > 0) ? ref_q[0] : -1;
        bit hack = (h == 1) ? dmem_ack : imem_ack;
        bit dropped;
        resp_t r;
        if (full) ereq = 1'b0;
        else if (lock == 0) begin ereq = imem_req; win = 0; end
        else if (lock == 1) begin ereq = dmem_req; win = 1; end
        else if (imem_req && dmem_req) begin
            ereq = 1'b1;
`ifdef FRV_MEM_ARB_RR_EN
            win = (rr_last == 1) ? 0 : 1;
`else
            win = 1;
`endif
        end else if (dmem_req) begin ereq = 1'b1; win = 1; end
        else if (imem_req) begin ereq = 1'b1; win = 0; end

        check("req_gnt", {bus_req, imem_gnt, dmem_gnt},
              {ereq, ereq && bus_gnt && win == 0, ereq && bus_gnt && win == 1});
        if (ereq)
            check("bus_payload", {bus_wen, bus_strb, bus_addr, bus_wdata},
                  {preq[win].wen, preq[win].strb, preq[win].addr, preq[win].wdata});
        check("resp_route", {imem_recv, dmem_recv, bus_ack, err_unexpected},
              {bus_recv && h == 0, bus_recv && h == 1, (h < 0) ? bus_recv : hack,
               bus_recv && h < 0});
        if (bus_recv && h == 0) check("nonowner_d", {dmem_error, dmem_rdata}, '0);
        if (bus_recv && h == 1) check("nonowner_i", {imem_error, imem_rdata}, '0);

        if (drove_mem && (h < 0 || hack)) void'(mem_q.pop_front());
        if (bus_recv && h >= 0 && hack) void'(ref_q.pop_front());

        if (ereq && bus_gnt) begin
            r.rdata = use_override ? resp_override : $urandom;
            r.err   = use_override ? 1'b0 : ($urandom_range(7) == 0);
            use_override = 1'b0;
            mem_q.push_back(r);
            if (win == 0) exp_q0.push_back(r); else exp_q1.push_back(r);
            ref_q.push_back(win);
            pend[win] = 1'b0;
            lock      = -1;
            rr_last   = win;
        end else if (ereq) lock = win;
        else lock = -1;

        for (int x = 0; x < 2; x++) begin
            dropped = 1'b0;
            if (pend[x] && $urandom_range(99) < drop_pct) begin
                pend[x] = 1'b0;
                dropped = 1'b1;
            end
            if (!pend[x] && !dropped && $urandom_range(99) < req_pct) begin
                pend[x]       = 1'b1;
                preq[x].wen   = 1'($urandom_range(1));
                preq[x].strb  = 4'($urandom_range(15));
                preq[x].addr  = $urandom;
                preq[x].wdata = $urandom;
            end
        end
    endtask

    task automatic step();
        drive_inputs();
        @(negedge g_clk);
        check_update();
        @(posedge g_clk);
        #1;
    endtask

    // Scoreboard monitor: every completed response beat must match the oldest expected one.
    always @(negedge g_clk) begin
        if (imem_recv && imem_ack) begin
            if (exp_q0.size() == 0) check("imem_unexpected_recv", imem_recv, 1'b0);
            else begin
                mon_r = exp_q0.pop_front();
                check("imem_resp", {imem_error, imem_rdata}, {mon_r.err, mon_r.rdata});
            end
        end
        if (dmem_recv && dmem_ack) begin
            if (exp_q1.size() == 0) check("dmem_unexpected_recv", dmem_recv, 1'b0);
            else begin
                mon_r = exp_q1.pop_front();
                check("dmem_resp", {dmem_error, dmem_rdata}, {mon_r.err, mon_r.rdata});
            end
        end
    end

    initial begin
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        set_knobs(0, 0, 0, 0, 0, 0);
        drive_zero();
        #12;
        check("reset_outputs", all_outputs(), '0);
        @(negedge g_clk);
        #2 g_resetn = 1'b1;
        @(posedge g_clk);
        #1;
        drive_zero();
        @(negedge g_clk);
        check("idle_outputs", all_outputs(), '0);
        @(posedge g_clk);
        #1;

        // Single instruction fetch granted immediately, then its response.
        pend[0] = 1'b1;
        preq[0] = '{wen: 1'b0, strb: 4'h0, addr: 32'h8000_0000, wdata: 32'h0};
        force_gnt = 1;
        use_override = 1'b1;
        resp_override = 32'h0000_0013;
        step();
        force_gnt = -1;
        set_knobs(0, 0, 100, 100, 0, 0);
        step();
        step();

        set_knobs(60, 70, 15, 70, 3, 0);     // fills the FIFO often
        repeat (600) step();
        set_knobs(40, 30, 50, 50, 5, 0);     // long holds and ack stalls
        repeat (600) step();
        set_knobs(20, 50, 60, 60, 0, 20);    // stray response beats while idle
        repeat (400) step();

        // Drain, then two outstanding plus a held imem request, then asynchronous reset.
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        set_knobs(0, 0, 100, 100, 0, 0);
        for (int i = 0; i < 100 && mem_q.size() > 0; i++) step();
        set_knobs(0, 0, 0, 0, 0, 0);
        pend[0] = 1'b1; preq[0].addr = 32'h0000_1000; force_gnt = 1; step();
        pend[1] = 1'b1; preq[1].addr = 32'h0000_2000; step();
        pend[0] = 1'b1; preq[0].addr = 32'h0000_3000; force_gnt = 0; step();
        drive_inputs();
        #2 g_resetn = 1'b0;
        #1;
        check("reset_async", {bus_req, imem_gnt, dmem_gnt, err_unexpected}, '0);
        ref_q.delete();
        exp_q0.delete();
        exp_q1.delete();
        lock = -1;
        rr_last = 0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        force_gnt = -1;
        drive_zero();
        @(negedge g_clk);
        check("reset_hold_outputs", all_outputs(), '0);
        #2 g_resetn = 1'b1;
        @(posedge g_clk);
        #1;
        set_knobs(0, 0, 100, 50, 0, 0);      // stale beats now arrive as unexpected
        for (int i = 0; i < 20 && mem_q.size() > 0; i++) step();

        set_knobs(50, 50, 40, 60, 2, 5);
        repeat (300) step();

        pend[0] = 1'b0;
        pend[1] = 1'b0;
        set_knobs(0, 0, 100, 100, 0, 0);
        for (int i = 0; i < 100 && mem_q.size() > 0; i++) step();
        check("undelivered_responses", exp_q0.size() + exp_q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
